// File: rtl/dtc_share_sched_if.sv
// Bundle of the request, classifier, response and counter signals around the
// shared decision-tree scheduler. The slave modport is the scheduler; the
// master modport is the surrounding system (producers, classifier, consumer).
interface dtc_share_sched_if #(
  parameter int N_REQ  = 4,
  parameter int FEAT_W = 8,
  parameter int CLS_W  = 2,
  parameter int CNT_W  = 16
) ();
  localparam int ID_W  = $clog2(N_REQ);
  localparam int N_CLS = 2**CLS_W;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*FEAT_W-1:0] req_feat;
  logic [N_REQ-1:0]        req_ready;
  logic [FEAT_W-1:0]       dt_inp;
  logic [CLS_W-1:0]        dt_outp;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [CLS_W-1:0]        rsp_class;
  logic                    cnt_clear;
  logic [N_CLS*CNT_W-1:0]  class_cnt;
  logic                    busy;

  modport master (
    output req_valid, req_feat, dt_outp, rsp_ready, cnt_clear,
    input  req_ready, dt_inp, rsp_valid, rsp_id, rsp_class, class_cnt, busy
  );

  modport slave (
    input  req_valid, req_feat, dt_outp, rsp_ready, cnt_clear,
    output req_ready, dt_inp, rsp_valid, rsp_id, rsp_class, class_cnt, busy
  );
endinterface

// File: rtl/dtc_share_sched.sv
// Round-robin scheduler sharing one combinational decision-tree classifier
// among N_REQ requesters. One feature is evaluated at a time: IDLE grants,
// EVAL samples the classifier, RESP holds the tagged result until consumed.
// Per-class hit counters saturate and can be cleared synchronously.
module dtc_share_sched #(
  parameter int N_REQ  = 4,
  parameter int FEAT_W = 8,
  parameter int CLS_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dtc_share_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int N_CLS = 2**CLS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [FEAT_W-1:0] feat_arr [N_REQ];
  logic [CNT_W-1:0]  cnt_q    [N_CLS];

  // Unpack the flat feature bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      feat_arr[i] = bus.req_feat[i*FEAT_W +: FEAT_W];
    end
  end

  // Round-robin search starting at rr_ptr; ID_W-bit addition wraps at N_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it holding its old value, which would infer a latch.
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grant decodes from state, req_valid and rr_ptr only; one-hot or zero.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found) begin
      bus.req_ready[winner] = 1'b1;
    end
  end

  // Transaction FSM with all response-side outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      bus.dt_inp    <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_class <= '0;
      bus.rsp_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.dt_inp <= feat_arr[winner];
            bus.rsp_id <= winner;
            bus.busy   <= 1'b1;
            state      <= EVAL;
          end
        end
        EVAL: begin
          bus.rsp_class <= bus.dt_outp;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= bus.rsp_id + ID_W'(1);
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Saturating per-class hit counters; clear takes priority over increment.
  always_ff @(posedge clk) begin
    // NOTE: this small counter array is architecturally visible, so it is
    // reset explicitly; large data memories would normally not be.
    if (!rst_n || bus.cnt_clear) begin
      for (int k = 0; k < N_CLS; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (state == EVAL && cnt_q[bus.dt_outp] != CNT_MAX) begin
      cnt_q[bus.dt_outp] <= cnt_q[bus.dt_outp] + CNT_W'(1);
    end
  end

  // Flatten the counters onto the output bus, class k at [k*CNT_W +: CNT_W].
  for (genvar k = 0; k < N_CLS; k++) begin : g_cnt_out
    assign bus.class_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
endmodule
